// File: rtl/pipe_if.sv
// Instruction-fetch stage: fetches words over a req/ack memory port and hands them to decode with a four-phase syn/ack.
// Optional build macro IF_MISALIGN_CHECK_EN: flags redirect targets with nonzero low bits and word-aligns them.
module pipe_if #(
    parameter int unsigned          REG_SZ   = 32,
    parameter logic [REG_SZ-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [REG_SZ-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              down_syn,
    input  logic              down_ack,
    output logic [31:0]       inst,
    output logic [REG_SZ-1:0] pc_out,
    input  logic              br_valid,
    input  logic [REG_SZ-1:0] br_target,
    output logic              misalign,
    output logic [1:0]        fsm_state
);

    // Downstream handshake: down_syn rises with a new inst/pc_out and holds them
    // until down_ack rises; the next fetch starts only after down_ack falls again.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        SEND    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [REG_SZ-1:0] pc, pc_n;
    logic [REG_SZ-1:0] tgt, tgt_n;
    logic              req_n, syn_n, squash, squash_n, redir_pend, pend_n;
    logic [31:0]       inst_n;
    logic [REG_SZ-1:0] pc_out_n;
    logic [REG_SZ-1:0] br_tgt;
    logic              br_accept;

    assign mem_addr  = pc;
    assign fsm_state = state;
    assign br_accept = br_valid && (state != IDLE);

`ifdef IF_MISALIGN_CHECK_EN
    assign br_tgt = {br_target[REG_SZ-1:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            misalign <= 1'b0;
        else if (br_accept && (br_target[1:0] != 2'b00))
            misalign <= 1'b1;
    end
`else
    assign br_tgt   = br_target;
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            tgt        <= '0;
            mem_req    <= 1'b0;
            down_syn   <= 1'b0;
            inst       <= '0;
            pc_out     <= '0;
            squash     <= 1'b0;
            redir_pend <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            tgt        <= tgt_n;
            mem_req    <= req_n;
            down_syn   <= syn_n;
            inst       <= inst_n;
            pc_out     <= pc_out_n;
            squash     <= squash_n;
            redir_pend <= pend_n;
        end
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        tgt_n    = tgt;
        req_n    = mem_req;
        syn_n    = down_syn;
        inst_n   = inst;
        pc_out_n = pc_out;
        squash_n = squash;
        pend_n   = redir_pend;
        case (state)
            IDLE: begin
                state_n = FETCH;
                req_n   = 1'b1;
            end
            FETCH: begin
                if (!mem_req) begin
                    // Gap cycle after a squash: nothing in flight, so a redirect applies directly.
                    req_n = 1'b1;
                    if (br_valid) pc_n = br_tgt;
                end else if (mem_ack) begin
                    if (!squash && !br_valid) begin
                        inst_n   = mem_rdata;
                        pc_out_n = pc;
                        req_n    = 1'b0;
                        syn_n    = 1'b1;
                        state_n  = SEND;
                    end else begin
                        pc_n     = br_valid ? br_tgt : tgt;
                        squash_n = 1'b0;
                        pend_n   = 1'b0;
                        req_n    = 1'b0;
                    end
                end else if (br_valid) begin
                    tgt_n    = br_tgt;
                    squash_n = 1'b1;
                end
            end
            SEND: begin
                if (br_valid) begin
                    tgt_n  = br_tgt;
                    pend_n = 1'b1;
                end
                if (down_ack) begin
                    syn_n   = 1'b0;
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                if (br_valid) begin
                    tgt_n  = br_tgt;
                    pend_n = 1'b1;
                end
                if (!down_ack) begin
                    if (br_valid)        pc_n = br_tgt;
                    else if (redir_pend) pc_n = tgt;
                    else                 pc_n = pc + REG_SZ'(4);
                    pend_n  = 1'b0;
                    req_n   = 1'b1;
                    state_n = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pipe_if.sv
// Directed bench for pipe_if: memory and decode responders, request/delivery scoreboards, redirect and reset scenarios.
module tb_pipe_if;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        down_syn;
    logic        down_ack = 1'b0;
    logic [31:0] inst;
    logic [31:0] pc_out;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = '0;
    logic        misalign;
    logic [1:0]  fsm_state;

    int vectors     = 0;
    int miscompares = 0;
    int mem_wait    = 2;
    bit track       = 1'b1;

    logic [31:0] exp_req_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_inst_q[$];

    pipe_if #(.REG_SZ(32), .RESET_PC(32'h100)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .down_syn(down_syn), .down_ack(down_ack), .inst(inst), .pc_out(pc_out),
        .br_valid(br_valid), .br_target(br_target), .misalign(misalign), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h00500093;
        return a ^ 32'h13579BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_deliver(input logic [31:0] a);
        exp_pc_q.push_back(a);
        exp_inst_q.push_back(mem_word(a));
    endtask

    // kind 0: request at addr; 1: offer of pc; 2: in RELEASE
    task automatic wait_for(input int kind, input logic [31:0] val, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            case (kind)
                0:       hit = mem_req && (mem_addr == val);
                1:       hit = down_syn && (pc_out == val);
                default: hit = (fsm_state == 2'd3);
            endcase
        end
        if (!hit) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic branch(input logic [31:0] t);
        br_valid  = 1'b1;
        br_target = t;
        @(negedge clk);
        br_valid  = 1'b0;
    endtask

    // Memory responder: ack after mem_wait cycles of request
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_ack = 1'b0;
                cnt = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req) begin
                if (cnt == mem_wait) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Decode responder: slow for pc 0x104, otherwise immediate
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                down_ack = 1'b0;
                cnt = 0;
            end else if (down_syn && !down_ack) begin
                if (cnt == ((pc_out == 32'h104) ? 5 : 0)) begin
                    down_ack = 1'b1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else if (!down_syn && down_ack) begin
                down_ack = 1'b0;
            end
        end
    end

    // Monitor: request addresses, deliveries, and stability of an offer
    initial begin
        logic        prev_req = 1'b0;
        logic        prev_syn = 1'b0;
        logic [31:0] prev_inst = '0;
        logic [31:0] prev_pc = '0;
        forever begin
            @(negedge clk);
            if (!rst && track) begin
                if (mem_req && !prev_req) begin
                    if (exp_req_q.size() == 0) check("unexpected_req", mem_addr, 32'hFFFF_FFFF);
                    else check("req_addr", mem_addr, exp_req_q.pop_front());
                end
                if (down_syn && !prev_syn) begin
                    if (exp_pc_q.size() == 0) begin
                        check("unexpected_offer", pc_out, 32'hFFFF_FFFF);
                    end else begin
                        check("offer_pc", pc_out, exp_pc_q.pop_front());
                        check("offer_inst", inst, exp_inst_q.pop_front());
                    end
                end
                if (down_syn && prev_syn) begin
                    check("hold_inst", inst, prev_inst);
                    check("hold_pc", pc_out, prev_pc);
                end
                if (down_syn) check("no_req_in_send", {31'd0, mem_req}, 32'd0);
            end
            prev_req  = mem_req;
            prev_syn  = down_syn;
            prev_inst = inst;
            prev_pc   = pc_out;
        end
    end

    initial begin
        logic [31:0] mis_addr;
        logic [31:0] mis_exp;
`ifdef IF_MISALIGN_CHECK_EN
        mis_addr = 32'h200;
        mis_exp  = 32'd1;
`else
        mis_addr = 32'h202;
        mis_exp  = 32'd0;
`endif
        exp_req_q = '{32'h100, 32'h104, 32'h108, 32'h200, 32'h300, 32'h400,
                      32'hFFFF_FFFC, 32'h0, mis_addr, mis_addr + 32'd4,
                      32'h100, 32'h600, 32'h604};
        expect_deliver(32'h100);
        expect_deliver(32'h104);
        expect_deliver(32'h200);
        expect_deliver(32'h300);
        expect_deliver(32'h400);
        expect_deliver(32'hFFFF_FFFC);
        expect_deliver(32'h0);
        expect_deliver(mis_addr);
        expect_deliver(32'h600);

        repeat (3) @(negedge clk);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_down_syn", {31'd0, down_syn}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h100);
        check("rst_state", {30'd0, fsm_state}, 32'd0);
        rst = 1'b0;

        // Redirect while fetch of 0x108 is still in flight
        wait_for(0, 32'h108, "wait_req_108");
        branch(32'h200);
        // Redirect during SEND of 0x200
        wait_for(1, 32'h200, "wait_offer_200");
        branch(32'h300);
        // Two redirects: one in SEND, a later one in the RELEASE exit cycle
        wait_for(1, 32'h300, "wait_offer_300");
        br_valid  = 1'b1;
        br_target = 32'h500;
        wait_for(2, 32'h0, "wait_release_300");
        branch(32'h400);
        // Wrap-around from the top of the address space
        wait_for(1, 32'h400, "wait_offer_400");
        branch(32'hFFFF_FFFC);
        // Misaligned target
        wait_for(1, 32'h0, "wait_offer_0");
        branch(32'h202);
        check("misalign_flag", {31'd0, misalign}, mis_exp);

        // Asynchronous reset in the middle of a fetch
        wait_for(0, mis_addr + 32'd4, "wait_req_after_mis");
        rst = 1'b1;
        #1;
        check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        check("midrst_down_syn", {31'd0, down_syn}, 32'd0);
        check("midrst_mem_addr", mem_addr, 32'h100);
        check("midrst_misalign", {31'd0, misalign}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Redirect in the same cycle as the ack of 0x100
        wait_for(0, 32'h100, "wait_req_100_again");
        repeat (2) @(negedge clk);
        branch(32'h600);

        for (int i = 0; i < 300 && (exp_req_q.size() != 0 || exp_pc_q.size() != 0); i++)
            @(negedge clk);
        track = 1'b0;
        check("req_queue_drained", exp_req_q.size(), 32'd0);
        check("offer_queue_drained", exp_pc_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
